// File: rtl/vga_pkg.sv
// vga_pkg: shared types and geometry constants for the VGA framebuffer path.
// Contents: fetch FSM state encoding, native 640x480 / 320x240 line geometry,
//           and the RGB332 pixel layout also used by the panel driver.
package vga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    UNPACK,
    DONE,
    DRAIN
  } state_t;

  // Reference geometry: the constants below describe the native 640x480 panel.
  // Other panel sizes scale them linearly against these.
  localparam int REF_H_ACTIVE      = 640;
  localparam int REF_V_ACTIVE      = 480;

  localparam int WORDS_PER_LINE_HI = 160;  // 640 px / 4 px per word
  localparam int WORDS_PER_LINE_LO = 80;   // 320 px / 4 px per word
  localparam int LINE_STRIDE_LO    = 320;  // bytes per low-res source line
  localparam int LINES_LO          = 240;  // low-res source lines

  // RGB332 pixel: red [7:5], green [4:2], blue [1:0].
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

endpackage

// File: rtl/vga_fb_unpack.sv
// vga_fb_unpack: serialises one 32-bit word into RGB332 bytes, LSB first,
// optionally emitting every byte twice (horizontal pixel doubling).
// Ports: clk/rst_n; load+load_data start a word; dup selects doubling;
//        full stalls output with data held; flush abandons the word;
//        wr_en/wr_data drive the FIFO; done flags the last accepted write.
module vga_fb_unpack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        dup,
  input  logic        full,
  input  logic        flush,
  output logic        wr_en,
  output logic [7:0]  wr_data,
  output logic        done
);

  logic [31:0] word_q;
  logic [1:0]  byte_idx;
  logic        second;   // second copy of the current byte in doubling mode
  logic        busy;
  logic        last_beat;

  assign last_beat = (byte_idx == 2'd3) && (!dup || second);

  // The strobe is simply "have data and FIFO not full", so every asserted
  // strobe is a completed write and no separate accept handshake is needed.
  assign wr_en   = busy & ~full;
  assign wr_data = word_q[7:0];
  assign done    = wr_en & last_beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= '0;
      byte_idx <= 2'd0;
      second   <= 1'b0;
      busy     <= 1'b0;
    end else if (flush) begin
      busy     <= 1'b0;
    end else if (load) begin
      word_q   <= load_data;
      byte_idx <= 2'd0;
      second   <= 1'b0;
      busy     <= 1'b1;
    end else if (wr_en) begin
      if (dup && !second) begin
        second <= 1'b1;
      end else begin
        second   <= 1'b0;
        word_q   <= {8'h00, word_q[31:8]};
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/vga_fb_dma.sv
// vga_fb_dma: fetches one frame per active-vertical period from memory over a
// single-outstanding req/ack bus and streams RGB332 pixels into the CDC FIFO.
// Ports: CFG_* sampled at frame start; ACTIVE_LINE_IN starts/aborts frames;
//        BUS_* word reads; FIFO_* pixel writes (stalled by full);
//        FRAME_DONE_OUT pulses once after the final pixel of a complete frame.
module vga_fb_dma
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 32
) (
  input  logic              CLK,
  input  logic              RST_ASYNC_N,
  input  logic [ADDR_W-1:0] CFG_FB_BASE_IN,
  input  logic              CFG_LOWRES_IN,
  input  logic              ACTIVE_LINE_IN,
  output logic              BUS_REQ_OUT,
  output logic [ADDR_W-1:0] BUS_ADDR_OUT,
  input  logic              BUS_ACK_IN,
  input  logic [31:0]       BUS_DATA_IN,
  output logic              FIFO_WR_EN_OUT,
  output logic [7:0]        FIFO_WR_DATA_OUT,
  input  logic              FIFO_FULL_IN,
  output logic              FRAME_DONE_OUT
);

  // Geometry scaled from the native 640x480 constants.
  localparam int WPL_HI    = H_ACTIVE * WORDS_PER_LINE_HI / REF_H_ACTIVE;
  localparam int WPL_LO    = H_ACTIVE * WORDS_PER_LINE_LO / REF_H_ACTIVE;
  localparam int STRIDE_LO = H_ACTIVE * LINE_STRIDE_LO / REF_H_ACTIVE;
  localparam int NLINES_LO = V_ACTIVE * LINES_LO / REF_V_ACTIVE;

  localparam int WORD_W = (WPL_HI > 1) ? $clog2(WPL_HI) : 1;
  localparam int LINE_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  localparam logic [ADDR_W-1:0] WORD_BYTES   = ADDR_W'(4);
  // Address register points at the last word of the line when rewinding.
  localparam logic [ADDR_W-1:0] REWIND       = ADDR_W'(STRIDE_LO - 4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK   = ~ADDR_W'(3);
  localparam logic [WORD_W-1:0] WORD_LAST_HI = WORD_W'(WPL_HI - 1);
  localparam logic [WORD_W-1:0] WORD_LAST_LO = WORD_W'(WPL_LO - 1);
  localparam logic [LINE_W-1:0] LINE_LAST_HI = LINE_W'(V_ACTIVE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST_LO = LINE_W'(NLINES_LO - 1);

  state_t            state;
  logic              active_q;
  logic              lowres_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] word_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic              rep_q;     // second pass over a low-res source line
  logic              bus_req_q;
  logic              frame_done_q;

  logic rise;
  logic fall;
  logic end_of_line;
  logic end_of_frame;
  logic unpack_load;
  logic unpack_flush;
  logic unpack_done;

  assign rise = ACTIVE_LINE_IN & ~active_q;
  assign fall = ~ACTIVE_LINE_IN & active_q;

  assign end_of_line  = word_cnt == (lowres_q ? WORD_LAST_LO : WORD_LAST_HI);
  assign end_of_frame = end_of_line
                      && (line_cnt == (lowres_q ? LINE_LAST_LO : LINE_LAST_HI))
                      && (!lowres_q || rep_q);

  // An ack coinciding with an abort is dropped rather than unpacked.
  assign unpack_load  = (state == REQ) && BUS_ACK_IN && !fall;
  assign unpack_flush = (state == UNPACK) && fall;

  vga_fb_unpack u_unpack (
    .clk       (CLK),
    .rst_n     (RST_ASYNC_N),
    .load      (unpack_load),
    .load_data (BUS_DATA_IN),
    .dup       (lowres_q),
    .full      (FIFO_FULL_IN),
    .flush     (unpack_flush),
    .wr_en     (FIFO_WR_EN_OUT),
    .wr_data   (FIFO_WR_DATA_OUT),
    .done      (unpack_done)
  );

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state        <= IDLE;
      active_q     <= 1'b0;
      lowres_q     <= 1'b0;
      addr_q       <= '0;
      word_cnt     <= '0;
      line_cnt     <= '0;
      rep_q        <= 1'b0;
      bus_req_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      active_q     <= ACTIVE_LINE_IN;
      frame_done_q <= 1'b0;

      case (state)
        IDLE: begin
          if (rise) begin
            addr_q    <= CFG_FB_BASE_IN & ALIGN_MASK;
            lowres_q  <= CFG_LOWRES_IN;
            word_cnt  <= '0;
            line_cnt  <= '0;
            rep_q     <= 1'b0;
            bus_req_q <= 1'b1;
            state     <= REQ;
          end
        end

        REQ: begin
          if (BUS_ACK_IN) begin
            bus_req_q <= 1'b0;
            state     <= fall ? IDLE : UNPACK;
          end else if (fall) begin
            // The bus cannot cancel a request: keep it up and swallow the ack.
            state <= DRAIN;
          end
        end

        UNPACK: begin
          if (fall) begin
            state <= IDLE;
          end else if (unpack_done) begin
            if (end_of_frame) begin
              frame_done_q <= 1'b1;
              state        <= DONE;
            end else begin
              bus_req_q <= 1'b1;
              state     <= REQ;
              if (!end_of_line) begin
                word_cnt <= word_cnt + 1'b1;
                addr_q   <= addr_q + WORD_BYTES;
              end else begin
                word_cnt <= '0;
                if (lowres_q && !rep_q) begin
                  // Refetch the same source line for vertical doubling.
                  rep_q  <= 1'b1;
                  addr_q <= addr_q - REWIND;
                end else begin
                  rep_q    <= 1'b0;
                  addr_q   <= addr_q + WORD_BYTES;
                  line_cnt <= line_cnt + 1'b1;
                end
              end
            end
          end
        end

        DONE: begin
          if (!ACTIVE_LINE_IN) begin
            state <= IDLE;
          end
        end

        DRAIN: begin
          if (BUS_ACK_IN) begin
            bus_req_q <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign BUS_REQ_OUT    = bus_req_q;
  assign BUS_ADDR_OUT   = addr_q;
  assign FRAME_DONE_OUT = frame_done_q;

endmodule

// File: tb/tb_vga_fb_dma.sv
// tb_vga_fb_dma: randomized scoreboard bench for vga_fb_dma on a reduced
// 32x8 panel; expected pixels and fetch addresses come from a screen-space
// model (output pixel -> source byte address -> memory byte).
module tb_vga_fb_dma;

  localparam int H = 32;
  localparam int V = 8;

  logic        CLK = 1'b0;
  logic        RST_ASYNC_N = 1'b0;
  logic [31:0] CFG_FB_BASE_IN = '0;
  logic        CFG_LOWRES_IN = 1'b0;
  logic        ACTIVE_LINE_IN = 1'b0;
  logic        BUS_REQ_OUT;
  logic [31:0] BUS_ADDR_OUT;
  logic        BUS_ACK_IN = 1'b0;
  logic [31:0] BUS_DATA_IN = '0;
  logic        FIFO_WR_EN_OUT;
  logic [7:0]  FIFO_WR_DATA_OUT;
  logic        FIFO_FULL_IN = 1'b0;
  logic        FRAME_DONE_OUT;

  vga_fb_dma #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(32)) dut (
    .CLK              (CLK),
    .RST_ASYNC_N      (RST_ASYNC_N),
    .CFG_FB_BASE_IN   (CFG_FB_BASE_IN),
    .CFG_LOWRES_IN    (CFG_LOWRES_IN),
    .ACTIVE_LINE_IN   (ACTIVE_LINE_IN),
    .BUS_REQ_OUT      (BUS_REQ_OUT),
    .BUS_ADDR_OUT     (BUS_ADDR_OUT),
    .BUS_ACK_IN       (BUS_ACK_IN),
    .BUS_DATA_IN      (BUS_DATA_IN),
    .FIFO_WR_EN_OUT   (FIFO_WR_EN_OUT),
    .FIFO_WR_DATA_OUT (FIFO_WR_DATA_OUT),
    .FIFO_FULL_IN     (FIFO_FULL_IN),
    .FRAME_DONE_OUT   (FRAME_DONE_OUT)
  );

  initial forever #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pix_q[$];
  logic [31:0] addr_q[$];
  int wr_count = 0;
  int done_cnt = 0;
  int frame_wr0 = 0;
  int done_before = 0;
  int mem_mode = 0;
  int ack_fixed = -1;   // -1: random 0..3 cycle ack latency
  int full_mode = 0;    // 0 never full, 1 random, 2 forced full

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_mode == 0) return a;
    if (a == 32'h0000_1000) return 32'h4433_2211;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference: every output pixel maps to one source byte address.
  task automatic model_frame(input logic [31:0] base, input bit lowres);
    logic [31:0] b, ba, w;
    int x, y;
    b = base & 32'hFFFF_FFFC;
    for (int p = 0; p < H * V; p++) begin
      x = p % H;
      y = p / H;
      ba = lowres ? b + 32'((y / 2) * (H / 2) + x / 2) : b + 32'(y * H + x);
      w = mem_word(ba & 32'hFFFF_FFFC);
      pix_q.push_back(8'(w >> (8 * ba[1:0])));
    end
    for (int yy = 0; yy < V; yy++)
      for (int k = 0; k < (lowres ? H / 8 : H / 4); k++)
        addr_q.push_back(lowres ? b + 32'((yy / 2) * (H / 2) + 4 * k)
                                : b + 32'(yy * H + 4 * k));
  endtask

  // Pixel / done monitor.
  always @(negedge CLK) begin
    if (RST_ASYNC_N) begin
      if (FIFO_WR_EN_OUT) begin
        check_eq("wr_while_full", 32'(FIFO_FULL_IN), 0);
        if (pix_q.size() == 0) begin
          check_eq("unexpected_write", 32'(FIFO_WR_DATA_OUT), 32'hFFFF_FFFF);
        end else begin
          check_eq("pixel", 32'(FIFO_WR_DATA_OUT), 32'(pix_q.pop_front()));
        end
        wr_count++;
      end
      if (FRAME_DONE_OUT) done_cnt++;
    end
  end

  // FIFO full generator.
  always begin
    @(posedge CLK); #1;
    case (full_mode)
      0:       FIFO_FULL_IN = 1'b0;
      1:       FIFO_FULL_IN = ($urandom_range(3) == 0);
      default: FIFO_FULL_IN = 1'b1;
    endcase
  end

  // Bus agent: acks after a latency, checks address stability while waiting.
  bit          waiting = 0;
  int          wait_cnt = 0;
  int          cur_delay = 0;
  logic [31:0] held_addr = '0;
  always begin
    @(posedge CLK); #1;
    if (BUS_ACK_IN) begin
      BUS_ACK_IN = 1'b0;
      waiting = 0;
    end else if (BUS_REQ_OUT && RST_ASYNC_N) begin
      if (!waiting) begin
        waiting = 1;
        wait_cnt = 0;
        held_addr = BUS_ADDR_OUT;
        cur_delay = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(3));
      end else begin
        check_eq("addr_stable", BUS_ADDR_OUT, held_addr);
        wait_cnt++;
      end
      if (wait_cnt >= cur_delay) begin
        if (addr_q.size() == 0) check_eq("unexpected_req", BUS_ADDR_OUT, 32'hDEAD_BEEF);
        else check_eq("bus_addr", BUS_ADDR_OUT, addr_q.pop_front());
        BUS_DATA_IN = mem_word(BUS_ADDR_OUT);
        BUS_ACK_IN = 1'b1;
      end
    end else begin
      waiting = 0;
    end
  end

  task automatic start_frame(input logic [31:0] base, input bit lowres);
    @(posedge CLK); #1;
    CFG_FB_BASE_IN = base;
    CFG_LOWRES_IN = lowres;
    model_frame(base, lowres);
    done_before = done_cnt;
    frame_wr0 = wr_count;
    ACTIVE_LINE_IN = 1'b1;
    // Configuration must be latched at the edge; disturb it afterwards.
    repeat (2) @(posedge CLK);
    #1;
    CFG_FB_BASE_IN = $urandom;
    CFG_LOWRES_IN = ~lowres;
  endtask

  task automatic finish_frame();
    bit seen;
    seen = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge CLK);
      if (done_cnt != done_before) begin seen = 1; break; end
    end
    check_eq("frame_done_seen", 32'(seen), 1);
    check_eq("write_total", 32'(wr_count - frame_wr0), 32'(H * V));
    check_eq("pixels_left", 32'(pix_q.size()), 0);
    check_eq("addrs_left", 32'(addr_q.size()), 0);
    @(posedge CLK); #1;
    ACTIVE_LINE_IN = 1'b0;
    repeat (5) @(negedge CLK);
    check_eq("done_pulse_count", 32'(done_cnt - done_before), 1);
    check_eq("idle_req", 32'(BUS_REQ_OUT), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_req"}, 32'(BUS_REQ_OUT), 0);
    check_eq({tag, "_addr"}, BUS_ADDR_OUT, 0);
    check_eq({tag, "_wr_en"}, 32'(FIFO_WR_EN_OUT), 0);
    check_eq({tag, "_done"}, 32'(FRAME_DONE_OUT), 0);
  endtask

  initial begin
    bit          ok;
    bit          lr;
    int          saved;
    int          dref;
    logic [31:0] base;

    repeat (3) @(posedge CLK);
    #1;
    check_outputs_zero("reset");
    RST_ASYNC_N = 1'b1;
    repeat (2) @(posedge CLK);

    // Hi-res, word = address, FIFO never full.
    mem_mode = 0; full_mode = 0; ack_fixed = -1;
    start_frame(32'h0, 1'b0);
    finish_frame();

    // Low-res at 0x1000 with a known first word.
    mem_mode = 1;
    start_frame(32'h0000_1000, 1'b1);
    finish_frame();

    // 50-cycle FIFO full in the middle of a word.
    lr = 1'($urandom_range(1));
    start_frame($urandom, lr);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge CLK); #2;
      if (FIFO_WR_EN_OUT && (wr_count - frame_wr0) >= 12
          && ((wr_count - frame_wr0) % (lr ? 8 : 4)) == 1) begin ok = 1; break; end
    end
    check_eq("hold_setup", 32'(ok), 1);
    full_mode = 2;
    @(posedge CLK); #2;
    saved = wr_count;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      check_eq("req_during_full", 32'(BUS_REQ_OUT), 0);
    end
    check_eq("writes_during_full", 32'(wr_count), 32'(saved));
    full_mode = 0;
    finish_frame();

    // Ack delayed 10 cycles on every request.
    ack_fixed = 10; full_mode = 1;
    start_frame($urandom, 1'b1);
    finish_frame();

    // Abort while a request is outstanding, then restart from base.
    ack_fixed = 5;
    base = $urandom;
    lr = 1'($urandom_range(1));
    start_frame(base, lr);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge CLK); #2;
      if ((wr_count - frame_wr0) >= 20 && BUS_REQ_OUT && !BUS_ACK_IN) begin ok = 1; break; end
    end
    check_eq("abort_setup", 32'(ok), 1);
    ACTIVE_LINE_IN = 1'b0;
    pix_q.delete();
    dref = done_cnt;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (BUS_ACK_IN) begin ok = 1; break; end
      check_eq("abort_req_held", 32'(BUS_REQ_OUT), 1);
    end
    check_eq("abort_ack_seen", 32'(ok), 1);
    @(posedge CLK); #2;
    check_eq("abort_req_drop", 32'(BUS_REQ_OUT), 0);
    addr_q.delete();
    repeat (10) @(negedge CLK);
    check_eq("abort_no_done", 32'(done_cnt), 32'(dref));
    ack_fixed = -1;
    start_frame(base, lr);
    finish_frame();

    // Asynchronous reset in the middle of unpacking.
    full_mode = 0;
    start_frame($urandom, 1'($urandom_range(1)));
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(posedge CLK); #2;
      if (FIFO_WR_EN_OUT && (wr_count - frame_wr0) >= 10) begin ok = 1; break; end
    end
    check_eq("reset_setup", 32'(ok), 1);
    #1 RST_ASYNC_N = 1'b0;
    #1 check_outputs_zero("async_reset");
    pix_q.delete();
    addr_q.delete();
    ACTIVE_LINE_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_ASYNC_N = 1'b1;
    dref = done_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check_eq("post_reset_idle", 32'(BUS_REQ_OUT), 0);
    end
    check_eq("post_reset_no_done", 32'(done_cnt), 32'(dref));
    start_frame($urandom, 1'b0);
    finish_frame();

    // Randomised frames, including an address wrap through zero.
    full_mode = 1;
    for (int f = 0; f < 6; f++) begin
      mem_mode = 1;
      base = (f == 0) ? 32'hFFFF_FF83 : $urandom;
      start_frame(base, 1'($urandom_range(1)));
      finish_frame();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_dma.md
Name: vga_fb_dma

Overview:
- Framebuffer fetch engine in the system clock domain, directly upstream of the vga_cdc FIFO that feeds the VGA panel driver.
- When the panel enters its active vertical region, reads the frame from memory as 32-bit words over a simple req/ack bus.
- Unpacks each word into 8-bit RGB332 pixels and writes them into the CDC FIFO, throttled by FIFO full.
- Supports native 640x480 and a 320x240 low-res mode, doubled on both axes to 640x480.

Parameters:
- H_ACTIVE, 640, visible pixels per output line
- V_ACTIVE, 480, visible output lines per frame
- ADDR_W, 32, bus address width

Ports:
- CLK  in  1  system clock
- RST_ASYNC_N  in  1  asynchronous active-low reset
- CFG_FB_BASE_IN  in  ADDR_W  framebuffer byte base address; word aligned, bits [1:0] ignored
- CFG_LOWRES_IN  in  1  0 = 640x480 source, 1 = 320x240 source doubled
- ACTIVE_LINE_IN  in  1  panel active-vertical-region level, already synchronised to CLK by vga_cdc
- BUS_REQ_OUT  out  1  read request
- BUS_ADDR_OUT  out  ADDR_W  read byte address
- BUS_ACK_IN  in  1  one-cycle acknowledge; BUS_DATA_IN is valid in the same cycle
- BUS_DATA_IN  in  32  read data
- FIFO_WR_EN_OUT  out  1  pixel write strobe
- FIFO_WR_DATA_OUT  out  8  pixel, RGB332
- FIFO_FULL_IN  in  1  CDC FIFO full
- FRAME_DONE_OUT  out  1  one-cycle pulse after the last pixel of a frame is written

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- Frame start and abort detection:
  - A registered copy of ACTIVE_LINE_IN is used for edge detection.
  - Rising edge = frame start.
  - Falling edge = frame abort.
- CFG_FB_BASE_IN and CFG_LOWRES_IN are sampled only at frame start and held for the whole frame.
- States:
  - IDLE: on rising edge -> REQ; address = base; word, line and repeat counters cleared.
  - REQ:
    - BUS_REQ_OUT = 1 with BUS_ADDR_OUT stable until BUS_ACK_IN.
    - On ack, capture BUS_DATA_IN -> UNPACK.
    - No prefetch: at most one outstanding request.
  - UNPACK:
    - Emit bytes little-endian: [7:0] first, [31:24] last.
    - In low-res mode, each byte is emitted twice back-to-back, giving 8 writes per word.
    - FIFO_WR_EN_OUT = !FIFO_FULL_IN, so every asserted strobe is accepted; FIFO full stalls the serialiser with data held.
    - After the last write of the word -> REQ for the next word, or DONE after the last word of the frame.
  - DONE: FRAME_DONE_OUT pulses on entry; wait for ACTIVE_LINE_IN low -> IDLE.
  - DRAIN: see the abort rule below.
- Addressing:
  - Hi-res: 160 words per line, 480 lines, address += 4 per word.
  - Low-res: 80 words per source line (320 B stride), 240 source lines.
  - Low-res line doubling: each source line is fetched twice. At the end of the first pass the address rewinds by 320 B and the repeat flag is set; at the end of the second pass the repeat flag clears and the address continues.
  - Both modes: exactly 307200 FIFO writes per frame. Address arithmetic wraps modulo 2^ADDR_W.
- Abort: falling edge of ACTIVE_LINE_IN in REQ or UNPACK.
  - From UNPACK -> IDLE immediately; no further writes.
  - From REQ: BUS_REQ_OUT must stay high until ack -> DRAIN. DRAIN discards the data and goes to IDLE the following cycle.
  - No FRAME_DONE_OUT is issued for an aborted frame.
- Simultaneous events: if ack and falling edge occur in the same cycle, the data is discarded (-> IDLE).
- Rising edge while in DRAIN: ignored. A frame only starts from IDLE.
- Reset mid-operation: asynchronous return to reset values; BUS_REQ_OUT drops immediately. The bus agent tolerates this.

Decomposition:
- Package vga_pkg:
  - state enum (IDLE, REQ, UNPACK, DONE, DRAIN)
  - constants: WORDS_PER_LINE_HI=160, WORDS_PER_LINE_LO=80, LINE_STRIDE_LO=320, LINES_LO=240
  - RGB332 field positions shared with the panel driver
- Sub-module vga_fb_unpack:
  - 32-bit word -> byte serialiser with optional duplication and full-stall.
  - Signals: load, done, wr_en, wr_data.

Test Plan:
- Hi-res frame, memory model returns word = address, FIFO never full:
  - exactly 307200 writes; first four bytes 00,00,00,00 from address base = 0x0;
  - bus addresses 0x0..0x4AFFC step 4;
  - one FRAME_DONE_OUT pulse.
- Low-res frame, base 0x1000, word at 0x1000 = 0x44332211:
  - first 8 writes 11,11,22,22,33,33,44,44;
  - addresses 0x1000..0x113C fetched twice, then 0x1140;
  - total 307200 writes.
- FIFO_FULL_IN held high for 50 cycles mid-word:
  - zero writes while full;
  - byte sequence resumes without loss or duplication;
  - BUS_REQ_OUT stays low throughout.
- ACK delayed 10 cycles:
  - BUS_REQ_OUT and BUS_ADDR_OUT stable for all 10 cycles;
  - exactly one capture.
- ACTIVE_LINE_IN falls while BUS_REQ_OUT is high:
  - request held until ack; data discarded; no FIFO write; no FRAME_DONE_OUT;
  - next rising edge restarts at base.
- RST_ASYNC_N asserted mid-UNPACK:
  - outputs go to 0 within the same cycle, without a clock edge;
  - after release, idle until the next rising edge of ACTIVE_LINE_IN.
